// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external-interrupt controller: config register
// addresses and controller state names.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_CFG_MASK = 2'd0;
    localparam logic [1:0] IRQ_CFG_MODE = 2'd1;
    localparam logic [1:0] IRQ_CFG_PEND = 2'd2;
    localparam logic [1:0] IRQ_CFG_STAT = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side bundle of the interrupt controller: EXE-stage config port plus the
// CP0 request / take / ERET handshake.
interface irq_ctrl_if #(
    parameter int ID_W = 4
);
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            ir_out;
    logic            ir_ack;
    logic            eoi;
    logic [ID_W-1:0] irq_id;
    logic            busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, ir_ack, eoi,
        input  cfg_rdata, ir_out, irq_id, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, ir_ack, eoi,
        output cfg_rdata, ir_out, irq_id, busy
    );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational priority encoder: the lowest-index asserted request wins.
module irq_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req[i] && !valid) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External-interrupt controller: synchronises, masks and prioritises NUM_SRC
// lines and drives one held request into CP0, tracking take and ERET.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          bus
);

    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] mask, mode, pend_edge;
    logic [NUM_SRC-1:0] pending, pm, edge_set, clr, id_onehot;
    logic [ID_W-1:0]    win_id, id_q, id_nxt;
    logic               win_valid, ack_clr;
    logic               wr_mask, wr_mode, wr_pend;
    irq_state_e         state, state_nxt;
    logic               unused_wdata;

    assign unused_wdata = ^bus.cfg_wdata[31:NUM_SRC];

    assign wr_mask = bus.cfg_we && (bus.cfg_addr == IRQ_CFG_MASK);
    assign wr_mode = bus.cfg_we && (bus.cfg_addr == IRQ_CFG_MODE);
    assign wr_pend = bus.cfg_we && (bus.cfg_addr == IRQ_CFG_PEND);

    // Level lines bypass the latch entirely; only edge-mode bits are stored.
    assign pending  = (mode & pend_edge) | (~mode & sync2);
    assign pm       = pending & mask;
    assign edge_set = sync2 & ~prev & mode;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            id_onehot[i] = (id_q == ID_W'(i));
        end
    end

    assign clr = (ack_clr ? id_onehot : '0)
               | (wr_pend ? bus.cfg_wdata[NUM_SRC-1:0] : '0);

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .req   (pm),
        .id    (win_id),
        .valid (win_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            mask      <= '0;
            mode      <= '0;
            pend_edge <= '0;
        end else begin
            sync1     <= irq_src;
            sync2     <= sync1;
            prev      <= sync2;
            // set after clear so a coincident edge survives an ack or W1C
            pend_edge <= ((pend_edge & ~clr) | edge_set) & mode;
            if (wr_mask) mask <= bus.cfg_wdata[NUM_SRC-1:0];
            if (wr_mode) mode <= bus.cfg_wdata[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IRQ_IDLE;
            id_q  <= '0;
        end else begin
            state <= state_nxt;
            id_q  <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        ack_clr   = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (win_valid) begin
                    state_nxt = IRQ_REQ;
                    id_nxt    = win_id;
                end
            end
            IRQ_REQ: begin
                // a take from CP0 outranks a same-cycle withdrawal of the source
                if (bus.ir_ack) begin
                    state_nxt = IRQ_SERVICE;
                    ack_clr   = 1'b1;
                end else if ((pm & id_onehot) == '0) begin
                    state_nxt = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (bus.eoi) state_nxt = IRQ_IDLE;
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    assign bus.ir_out = (state == IRQ_REQ);
    assign bus.busy   = (state != IRQ_IDLE);
    assign bus.irq_id = id_q;

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            IRQ_CFG_MASK: bus.cfg_rdata[NUM_SRC-1:0] = mask;
            IRQ_CFG_MODE: bus.cfg_rdata[NUM_SRC-1:0] = mode;
            IRQ_CFG_PEND: bus.cfg_rdata[NUM_SRC-1:0] = pending;
            IRQ_CFG_STAT: bus.cfg_rdata[ID_W:0]      = {bus.busy, id_q};
            default:      bus.cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = '0;
    int         n_checks = 0;
    int         n_fail = 0;

    irq_ctrl_if #(.ID_W(4)) bus ();

    irq_ctrl #(.NUM_SRC(8), .ID_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: line history, enables, latched edges, and the
    // requesting / in-service flags with the source being handled.
    logic [7:0] m_s1 = '0, m_s2 = '0, m_pv = '0;
    logic [7:0] m_mask = '0, m_mode = '0, m_pe = '0;
    bit         m_req = 0, m_svc = 0;
    int         m_id = 0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_pending();
        return (m_mode & m_pe) | (~m_mode & m_s2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] pm, setb, clrb;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_pv = '0;
            m_mask = '0; m_mode = '0; m_pe = '0;
            m_req = 0; m_svc = 0; m_id = 0;
        end else begin
            pm   = m_pending() & m_mask;
            setb = m_s2 & ~m_pv & m_mode;
            clrb = '0;
            if (m_req) begin
                if (bus.ir_ack) begin
                    m_req = 0; m_svc = 1; clrb[m_id] = 1'b1;
                end else if (!pm[m_id]) begin
                    m_req = 0;
                end
            end else if (m_svc) begin
                if (bus.eoi) m_svc = 0;
            end else if (pm != 0) begin
                m_id  = lowest(pm);
                m_req = 1;
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd2) clrb |= bus.cfg_wdata[7:0];
            m_pe = ((m_pe & ~clrb) | setb) & m_mode;
            if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata[7:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd1) m_mode = bus.cfg_wdata[7:0];
            m_pv = m_s2; m_s2 = m_s1; m_s1 = irq_src;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_rd;
        exp_rd = '0;
        case (bus.cfg_addr)
            2'd0: exp_rd[7:0] = m_mask;
            2'd1: exp_rd[7:0] = m_mode;
            2'd2: exp_rd[7:0] = m_pending();
            default: exp_rd[4:0] = {m_req | m_svc, 4'(m_id)};
        endcase
        check("model_ir_out", 32'(bus.ir_out), 32'(m_req));
        check("model_busy", 32'(bus.busy), 32'(m_req | m_svc));
        check("model_irq_id", 32'(bus.irq_id), 32'(m_id));
        check("model_rdata", bus.cfg_rdata, exp_rd);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.cfg_addr = a;
        #1;
        check(name, bus.cfg_rdata, exp);
    endtask

    task automatic pulse_src(input logic [7:0] v);
        irq_src = v;
        tick();
        irq_src = '0;
    endtask

    task automatic pulse_ack_eoi(input bit a, input bit e);
        bus.ir_ack = a; bus.eoi = e;
        tick();
        bus.ir_ack = 1'b0; bus.eoi = 1'b0;
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        bus.ir_ack = 1'b0; bus.eoi = 1'b0;
        #2;
        check("rst_ir_out", 32'(bus.ir_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_irq_id", 32'(bus.irq_id), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // edge flow on source 2
        cfg_write(2'd0, 32'h04);
        cfg_write(2'd1, 32'h04);
        pulse_src(8'h04);
        tick(2);
        check("edge_not_yet", 32'(bus.ir_out), 32'd0);
        tick();
        check("edge_ir_out", 32'(bus.ir_out), 32'd1);
        check("edge_id", 32'(bus.irq_id), 32'd2);
        pulse_ack_eoi(1, 0);
        check("edge_ack_ir_out", 32'(bus.ir_out), 32'd0);
        read_chk("edge_ack_pend", 2'd2, 32'h0);
        pulse_ack_eoi(0, 1);
        check("edge_eoi_busy", 32'(bus.busy), 32'd0);
        tick(2);
        check("edge_no_rereq", 32'(bus.ir_out), 32'd0);

        // priority and no nesting
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd1, 32'hFF);
        pulse_src(8'h22);
        tick(3);
        check("prio_id1", 32'(bus.irq_id), 32'd1);
        read_chk("prio_pend", 2'd2, 32'h22);
        pulse_ack_eoi(1, 0);
        read_chk("prio_pend_svc", 2'd2, 32'h20);
        pulse_ack_eoi(0, 1);
        check("prio_gap", 32'(bus.ir_out), 32'd0);
        tick();
        check("prio_ir_out5", 32'(bus.ir_out), 32'd1);
        check("prio_id5", 32'(bus.irq_id), 32'd5);
        pulse_ack_eoi(1, 0);
        pulse_ack_eoi(0, 1);

        // level cancel and re-request on source 0
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd1, 32'h00);
        irq_src = 8'h01;
        tick(3);
        check("lvl_req", 32'(bus.ir_out), 32'd1);
        irq_src = 8'h00;
        tick(2);
        check("lvl_still_req", 32'(bus.ir_out), 32'd1);
        tick();
        check("lvl_cancel", 32'(bus.ir_out), 32'd0);
        check("lvl_cancel_busy", 32'(bus.busy), 32'd0);
        irq_src = 8'h01;
        tick(3);
        check("lvl_req2", 32'(bus.ir_out), 32'd1);
        pulse_ack_eoi(1, 0);
        check("lvl_svc_busy", 32'(bus.busy), 32'd1);
        pulse_ack_eoi(0, 1);
        check("lvl_idle_gap", 32'(bus.ir_out), 32'd0);
        tick();
        check("lvl_rereq", 32'(bus.ir_out), 32'd1);
        irq_src = 8'h00;
        tick(3);
        check("lvl_drop_idle", 32'(bus.busy), 32'd0);

        // masked pending and write-1-to-clear on source 3
        cfg_write(2'd0, 32'h00);
        cfg_write(2'd1, 32'h08);
        pulse_src(8'h08);
        tick(2);
        read_chk("w1c_pend", 2'd2, 32'h08);
        check("w1c_masked", 32'(bus.ir_out), 32'd0);
        cfg_write(2'd2, 32'h08);
        read_chk("w1c_cleared", 2'd2, 32'h00);
        pulse_src(8'h08);
        tick(3);
        read_chk("w1c_pend2", 2'd2, 32'h08);
        cfg_write(2'd0, 32'h08);
        check("unmask_wait", 32'(bus.ir_out), 32'd0);
        tick();
        check("unmask_req", 32'(bus.ir_out), 32'd1);
        check("unmask_id", 32'(bus.irq_id), 32'd3);

        // ack and eoi together: ack wins
        pulse_ack_eoi(1, 1);
        check("ackeoi_busy", 32'(bus.busy), 32'd1);
        read_chk("ackeoi_status", 2'd3, 32'h13);
        tick();
        check("ackeoi_hold", 32'(bus.busy), 32'd1);
        pulse_ack_eoi(0, 1);
        check("ackeoi_done", 32'(bus.busy), 32'd0);

        // asynchronous reset while requesting
        pulse_src(8'h08);
        tick(3);
        check("rreq_ir_out", 32'(bus.ir_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ir_out", 32'(bus.ir_out), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        read_chk("arst_mask", 2'd0, 32'h0);
        read_chk("arst_pend", 2'd2, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (8'h01 << $urandom_range(0, 7));
            bus.cfg_we    = ($urandom_range(0, 9) == 0);
            bus.cfg_addr  = 2'($urandom_range(0, 3));
            bus.cfg_wdata = $urandom;
            bus.ir_ack    = bus.ir_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            bus.eoi       = ($urandom_range(0, 4) == 0);
            tick();
        end
        bus.cfg_we = 1'b0; bus.ir_ack = 1'b0; bus.eoi = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable external-interrupt controller; the transmitting end of the CP0 interrupt interface.
- Collects NUM_SRC asynchronous interrupt lines, then synchronises, masks and prioritises them.
- Drives a single held request to CP0's interrupt input and tracks CP0's take (ack) and ERET (end-of-interrupt).
- CPU-visible config registers are accessed from the EXE stage over a simple write/read port.

Parameters:
- NUM_SRC, 8, number of interrupt source lines (1..16).
- ID_W, 4, width of source id field; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  input  1  main clock
- rst_n  input  1  asynchronous active-low reset
- irq_src  input  NUM_SRC  raw asynchronous interrupt lines, active-high
- cfg_we  input  1  config write strobe
- cfg_addr  input  2  config register select
- cfg_wdata  input  32  config write data
- cfg_rdata  output  32  config read data, combinational from cfg_addr
- ir_out  output  1  interrupt request to CP0 ir_in; held high while requesting
- ir_ack  input  1  one-cycle pulse: CP0 has taken the interrupt (jump to handler issued)
- eoi  input  1  one-cycle pulse: ERET executed
- irq_id  output  ID_W  id of the request/in-service source
- busy  output  1  high in REQ or SERVICE

Behaviour:
- Reset (async, rst_n=0) clears:
  - MASK=0 (all sources masked) and MODE=0 (all level-sensitive);
  - PENDING=0, synchroniser flops=0, edge-history register=0;
  - FSM=IDLE; ir_out=0, irq_id=0, busy=0.
- Synchroniser: 2-FF per line. Edge detect is sync2 & ~prev, where prev is sync2 delayed one cycle.
- PENDING[i]:
  - Edge mode (MODE[i]=1): set on a detected rising edge. Cleared when that source is acked, or by a cfg write-1-to-clear.
  - Level mode: PENDING[i] equals sync2[i]. Never latched; writes are ignored.
  - Simultaneous set and clear on the same cycle: set wins.
- Config map (cfg_rdata upper bits zero):
  - 0 = MASK (RW, 1 = enabled);
  - 1 = MODE (RW);
  - 2 = PENDING (R; write-1-clears edge bits);
  - 3 = STATUS (R: bit[ID_W]=busy, bits[ID_W-1:0]=irq_id).
- Priority: among PENDING & MASK, the lowest index wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if any PENDING & MASK, latch the winning id into irq_id, go to REQ, assert ir_out.
  - REQ: hold ir_out=1 and irq_id stable.
    - On ir_ack: go to SERVICE, ir_out=0, clear PENDING[irq_id] if edge mode.
    - If the latched source is no longer pending&masked before ack (level dropped or mask written): cancel, ir_out=0, go to IDLE. No re-arbitration inside REQ.
  - SERVICE: ir_out=0 and irq_id held. Other sources stay pending (no nesting). On eoi go to IDLE.
  - A new request may start no earlier than the cycle after returning to IDLE (minimum 1-cycle ir_out gap).
- Simultaneous events:
  - ir_ack and eoi together in REQ: ack wins, eoi dropped.
  - eoi outside SERVICE: ignored.
  - ir_ack outside REQ: ignored.
- Latency: a rising edge on irq_src sampled at clock edge k gives ir_out=1 after edge k+4 (2 sync, 1 pending/edge, 1 FSM), provided the FSM is IDLE and the source is enabled.
- Level source still high after eoi: re-requested, same latency from IDLE (1 cycle).
- Config writes take effect the next cycle. A MASK change in SERVICE does not affect the in-service id.

Decomposition:
- Shared package (irq_define.vh, included like mips_define.vh) holds:
  - config addresses IRQ_CFG_MASK/MODE/PEND/STAT;
  - FSM state encodings IRQ_IDLE/REQ/SERVICE.
- One natural sub-module: irq_prio_enc (combinational lowest-index priority encoder, NUM_SRC in, ID_W id + valid out).
- Synchroniser stays inline.

Test Plan:
- Reset mid-REQ: with ir_out=1, pulse rst_n low -> ir_out=0, busy=0, MASK=0, PENDING=0 immediately (asynchronous).
- Edge flow: MASK=0x04, MODE=0x04, 1-cycle pulse on irq_src[2] at edge k:
  - -> ir_out=1 at k+4, irq_id=2;
  - ir_ack -> ir_out=0, PENDING=0;
  - eoi -> busy=0, no re-request.
- Priority/no nesting: MASK=0xFF, MODE=0xFF, edges on src 5 and src 1 in the same cycle:
  - -> irq_id=1 first;
  - after ack+eoi -> irq_id=5 requested; src 5 stayed pending during SERVICE of src 1.
- Level cancel and re-request: MASK=0x01, MODE=0:
  - irq_src[0] high, then low before ack -> ir_out drops 3 cycles after the fall and state=IDLE;
  - held high through ack+eoi -> new request 1 cycle after eoi.
- Masked pending and W1C:
  - MODE=0x08, MASK=0, edge on src 3 -> PENDING reads 0x08, ir_out stays 0;
  - write PENDING=0x08 -> reads 0;
  - repeat the edge, then MASK=0x08 -> ir_out=1 the next-but-one cycle.
- ack+eoi same cycle in REQ -> state SERVICE, busy=1; a later eoi returns to IDLE.
